// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared types and defaults for the memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

   localparam int DEF_ADDR_W       = 32;
   localparam int DEF_DATA_W       = 32;
   localparam int DEF_STARVE_LIMIT = 3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_BUSY_IF  = 2'd1,
      ST_BUSY_LSU = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      REQ_NONE = 2'd0,
      REQ_IF   = 2'd1,
      REQ_LSU  = 2'd2
   } req_id_e;

   // Counter must hold 0..limit; never collapse to zero width.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module  : mem_arb_pick
// Brief   : Combinational winner select, LSU first unless IF is starved.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int CNT_W        = cnt_width(DEF_STARVE_LIMIT)
) (
   input  logic             i_if_req,
   input  logic             i_lsu_req,
   input  logic [CNT_W-1:0] i_starve_cnt,
   output req_id_e          o_winner
);

   logic starved;

   assign starved = (i_starve_cnt == CNT_W'(STARVE_LIMIT)) & i_if_req & i_lsu_req;

   always_comb begin
      o_winner = REQ_NONE;
      if (i_lsu_req && !starved) begin
         o_winner = REQ_LSU;
      end else if (i_if_req) begin
         o_winner = REQ_IF;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Single-outstanding arbiter sharing one memory port between IF/LSU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_if_req,
   input  logic [ADDR_W-1:0]   i_if_addr,
   input  logic                i_flush_if,
   output logic                o_if_gnt,
   output logic                o_if_rvalid,
   output logic [DATA_W-1:0]   o_if_rdata,
   input  logic                i_lsu_req,
   input  logic                i_lsu_we,
   input  logic [ADDR_W-1:0]   i_lsu_addr,
   input  logic [DATA_W-1:0]   i_lsu_wdata,
   input  logic [DATA_W/8-1:0] i_lsu_be,
   output logic                o_lsu_gnt,
   output logic                o_lsu_rvalid,
   output logic [DATA_W-1:0]   o_lsu_rdata,
   output logic                o_mem_req,
   output logic                o_mem_we,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_wdata,
   output logic [DATA_W/8-1:0] o_mem_be,
   input  logic                i_mem_ack,
   input  logic [DATA_W-1:0]   i_mem_rdata,
   output logic                o_stall_if,
   output logic                o_stall_mem
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = cnt_width(STARVE_LIMIT);

   arb_state_e          state_q;
   logic [CNT_W-1:0]    starve_q;
   logic                flushed_q;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [BE_W-1:0]     mem_be_q;
   logic                if_rvalid_q;
   logic                lsu_rvalid_q;
   logic [DATA_W-1:0]   if_rdata_q;
   logic [DATA_W-1:0]   lsu_rdata_q;

   logic                busy_ack;
   logic                can_arb;
   logic                if_req_ok;
   logic                if_gnt;
   logic                lsu_gnt;
   req_id_e             winner;

   // An ack seen while idle belongs to nobody and must not open a slot.
   assign busy_ack  = (state_q != ST_IDLE) & i_mem_ack;
   assign can_arb   = (state_q == ST_IDLE) | busy_ack;
   assign if_req_ok = i_if_req & ~i_flush_if;

   mem_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CNT_W        (CNT_W)
   ) u_pick (
      .i_if_req     (if_req_ok),
      .i_lsu_req    (i_lsu_req),
      .i_starve_cnt (starve_q),
      .o_winner     (winner)
   );

   // Gating with reset keeps every output low while reset is held.
   assign if_gnt  = i_reset_n & can_arb & (winner == REQ_IF);
   assign lsu_gnt = i_reset_n & can_arb & (winner == REQ_LSU);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q      <= ST_IDLE;
         starve_q     <= '0;
         flushed_q    <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
         if_rvalid_q  <= 1'b0;
         lsu_rvalid_q <= 1'b0;
         if_rdata_q   <= '0;
         lsu_rdata_q  <= '0;
      end else begin
         if_rvalid_q  <= 1'b0;
         lsu_rvalid_q <= 1'b0;

         if (busy_ack) begin
            if ((state_q == ST_BUSY_IF) && !(flushed_q || i_flush_if)) begin
               if_rvalid_q <= 1'b1;
               if_rdata_q  <= i_mem_rdata;
            end
            if (state_q == ST_BUSY_LSU) begin
               lsu_rvalid_q <= 1'b1;
               lsu_rdata_q  <= i_mem_rdata;
            end
         end

         if ((state_q == ST_BUSY_IF) && i_flush_if) begin
            flushed_q <= 1'b1;
         end

         if (if_gnt) begin
            state_q     <= ST_BUSY_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= i_if_addr;
            mem_wdata_q <= '0;
            mem_be_q    <= '1;
            flushed_q   <= 1'b0;
            starve_q    <= '0;
         end else if (lsu_gnt) begin
            state_q     <= ST_BUSY_LSU;
            mem_req_q   <= 1'b1;
            mem_we_q    <= i_lsu_we;
            mem_addr_q  <= i_lsu_addr;
            mem_wdata_q <= i_lsu_wdata;
            mem_be_q    <= i_lsu_be;
            flushed_q   <= 1'b0;
            if (i_if_req && (starve_q != CNT_W'(STARVE_LIMIT))) begin
               starve_q <= starve_q + CNT_W'(1);
            end
         end else if (busy_ack) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            flushed_q <= 1'b0;
         end
      end
   end

   assign o_if_gnt     = if_gnt;
   assign o_lsu_gnt    = lsu_gnt;
   assign o_if_rvalid  = if_rvalid_q;
   assign o_if_rdata   = if_rdata_q;
   assign o_lsu_rvalid = lsu_rvalid_q;
   assign o_lsu_rdata  = lsu_rdata_q;
   assign o_mem_req    = mem_req_q;
   assign o_mem_we     = mem_we_q;
   assign o_mem_addr   = mem_addr_q;
   assign o_mem_wdata  = mem_wdata_q;
   assign o_mem_be     = mem_be_q;
   assign o_stall_if   = i_reset_n & ((i_if_req & ~if_gnt) |
                                      ((state_q == ST_BUSY_IF) & ~i_mem_ack));
   assign o_stall_mem  = i_reset_n & ((i_lsu_req & ~lsu_gnt) |
                                      ((state_q == ST_BUSY_LSU) & ~i_mem_ack));

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Scoreboard bench for mem_port_arbiter with a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   localparam int LIMIT = 3;

   logic        clk;
   logic        rst_n;
   logic        if_req, flush_if, lsu_req, lsu_we, mem_ack;
   logic [31:0] if_addr, lsu_addr, lsu_wdata, mem_rdata;
   logic [3:0]  lsu_be;
   logic        if_gnt, if_rvalid, lsu_gnt, lsu_rvalid;
   logic        mem_req, mem_we, stall_if, stall_mem;
   logic [31:0] if_rdata, lsu_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   mem_port_arbiter #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .i_clk        (clk),
      .i_reset_n    (rst_n),
      .i_if_req     (if_req),
      .i_if_addr    (if_addr),
      .i_flush_if   (flush_if),
      .o_if_gnt     (if_gnt),
      .o_if_rvalid  (if_rvalid),
      .o_if_rdata   (if_rdata),
      .i_lsu_req    (lsu_req),
      .i_lsu_we     (lsu_we),
      .i_lsu_addr   (lsu_addr),
      .i_lsu_wdata  (lsu_wdata),
      .i_lsu_be     (lsu_be),
      .o_lsu_gnt    (lsu_gnt),
      .o_lsu_rvalid (lsu_rvalid),
      .o_lsu_rdata  (lsu_rdata),
      .o_mem_req    (mem_req),
      .o_mem_we     (mem_we),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .o_mem_be     (mem_be),
      .i_mem_ack    (mem_ack),
      .i_mem_rdata  (mem_rdata),
      .o_stall_if   (stall_if),
      .o_stall_mem  (stall_mem)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_now(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct { bit g_if; bit g_lsu; bit s_if; bit s_mem; } gnt_t;
   typedef struct { int start; bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } txn_t;
   typedef struct { int due; logic [31:0] data; } rsp_t;

   gnt_t gq[$];
   txn_t tq[$];
   rsp_t ifq[$];
   rsp_t lsq[$];

   // Reference model: who owns the port, whether the fetch was flushed, starvation depth.
   int   m_owner;
   bit   m_flushed;
   int   m_starve;
   bit   m_ack_here, m_slot, m_want_if;
   int   m_win;
   gnt_t m_g;
   txn_t m_t;
   rsp_t m_r;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_owner = 0; m_flushed = 0; m_starve = 0;
         gq.delete(); tq.delete(); ifq.delete(); lsq.delete();
      end else begin
         m_ack_here = (m_owner != 0) && mem_ack;
         m_slot     = (m_owner == 0) || m_ack_here;
         m_want_if  = if_req && !flush_if;
         m_win      = 0;
         if (m_slot) begin
            if (lsu_req && !(m_want_if && m_starve == LIMIT)) m_win = 2;
            else if (m_want_if)                               m_win = 1;
         end
         m_g.g_if  = (m_win == 1);
         m_g.g_lsu = (m_win == 2);
         m_g.s_if  = (if_req && m_win != 1) || (m_owner == 1 && !mem_ack);
         m_g.s_mem = (lsu_req && m_win != 2) || (m_owner == 2 && !mem_ack);
         gq.push_back(m_g);
         if (m_owner == 1 && flush_if) m_flushed = 1;
         if (m_ack_here) begin
            m_r.due  = cyc + 1;
            m_r.data = mem_rdata;
            if (m_owner == 1 && !m_flushed) ifq.push_back(m_r);
            if (m_owner == 2)               lsq.push_back(m_r);
            m_owner = 0; m_flushed = 0;
         end
         if (m_win == 1) begin
            m_t.start = cyc + 1; m_t.we = 0; m_t.addr = if_addr; m_t.wdata = 0; m_t.be = 4'hF;
            tq.push_back(m_t);
            m_owner = 1; m_flushed = 0; m_starve = 0;
         end else if (m_win == 2) begin
            m_t.start = cyc + 1; m_t.we = lsu_we; m_t.addr = lsu_addr; m_t.wdata = lsu_wdata; m_t.be = lsu_be;
            tq.push_back(m_t);
            m_owner = 2; m_flushed = 0;
            if (if_req && m_starve < LIMIT) m_starve++;
         end
      end
   end

   gnt_t c_g;
   txn_t c_t;
   rsp_t c_r;
   bit   c_exp_req;

   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         if (gq.size() == 0) begin
            fail_now("gnt_queue_empty", 0, 1);
         end else begin
            c_g = gq.pop_front();
            chk("if_gnt",    if_gnt,    c_g.g_if);
            chk("lsu_gnt",   lsu_gnt,   c_g.g_lsu);
            chk("stall_if",  stall_if,  c_g.s_if);
            chk("stall_mem", stall_mem, c_g.s_mem);
         end
         c_exp_req = (tq.size() > 0) && (tq[0].start <= cyc);
         chk("mem_req", mem_req, c_exp_req);
         if (mem_req && c_exp_req) begin
            c_t = tq[0];
            chk("mem_we",   mem_we,   c_t.we);
            chk("mem_addr", mem_addr, c_t.addr);
            chk("mem_be",   mem_be,   c_t.be);
            if (c_t.we) chk("mem_wdata", mem_wdata, c_t.wdata);
            if (mem_ack) void'(tq.pop_front());
         end
         if (if_rvalid) begin
            if (ifq.size() == 0) fail_now("if_rvalid_spurious", 1, 0);
            else begin
               c_r = ifq.pop_front();
               chk("if_rvalid_cycle", cyc, c_r.due);
               chk("if_rdata", if_rdata, c_r.data);
            end
         end else if (ifq.size() > 0 && ifq[0].due <= cyc) begin
            void'(ifq.pop_front());
            fail_now("if_rvalid_missing", 0, 1);
         end
         if (lsu_rvalid) begin
            if (lsq.size() == 0) fail_now("lsu_rvalid_spurious", 1, 0);
            else begin
               c_r = lsq.pop_front();
               chk("lsu_rvalid_cycle", cyc, c_r.due);
               chk("lsu_rdata", lsu_rdata, c_r.data);
            end
         end else if (lsq.size() > 0 && lsq[0].due <= cyc) begin
            void'(lsq.pop_front());
            fail_now("lsu_rvalid_missing", 0, 1);
         end
      end
   end

   task automatic step(input bit ir, input logic [31:0] ia, input bit fl,
                       input bit lr, input bit lw, input logic [31:0] la,
                       input logic [31:0] wd, input logic [3:0] be,
                       input bit ack, input logic [31:0] rd);
      if_req = ir; if_addr = ia; flush_if = fl;
      lsu_req = lr; lsu_we = lw; lsu_addr = la; lsu_wdata = wd; lsu_be = be;
      mem_ack = ack; mem_rdata = rd;
      @(posedge clk); #1;
   endtask

   task automatic idle(input bit ack);
      step(0, 0, 0, 0, 0, 0, 0, 0, ack, 32'h0BAD_0000);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_outs"},
          {32'b0, if_gnt, if_rvalid, lsu_gnt, lsu_rvalid, mem_req, mem_we, stall_if, stall_mem, mem_be},
          64'h0);
      chk({tag, "_rdata"}, {if_rdata, lsu_rdata}, 64'h0);
      chk({tag, "_mem"},   {mem_addr, mem_wdata}, 64'h0);
   endtask

   int ack_pct;

   initial begin
      rst_n = 1'b0;
      if_req = 0; if_addr = 0; flush_if = 0; lsu_req = 0; lsu_we = 0;
      lsu_addr = 0; lsu_wdata = 0; lsu_be = 0; mem_ack = 0; mem_rdata = 0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset_init");
      rst_n = 1'b1;
      idle(0);

      // IF-only fetch, ack three cycles after grant.
      step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(0); idle(0);
      idle(1); mem_rdata = 32'hDEAD_BEEF; @(posedge clk); #1;
      idle(0);
      // Contention: LSU first, IF granted in the LSU ack cycle.
      step(1, 32'h200, 0, 1, 0, 32'h300, 0, 4'hF, 0, 0);
      step(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 32'h1111_2222);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3333_4444);
      idle(0);
      // Starvation: both requesting, ack every cycle.
      step(1, 32'h400, 0, 1, 0, 32'h500, 0, 4'hF, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 32'h400 + i, 0, 1, 0, 32'h500 + i, 0, 4'hF, 1, 32'hA0 + i);
      idle(1); idle(0);
      // Flush of an in-flight fetch, LSU takes the ack-cycle slot.
      step(1, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 32'h700, 0, 4'hF, 1, 32'hFFFF_0000);
      idle(1); idle(0);
      // Partial store held until ack.
      step(0, 0, 0, 1, 1, 32'h800, 32'h1234, 4'b0011, 0, 0);
      idle(0); idle(0); idle(1); idle(0);

      // Reset in the middle of an LSU read.
      step(0, 0, 0, 1, 0, 32'h900, 0, 4'hF, 0, 0);
      idle(0);
      #2;
      if_req = 1; lsu_req = 1; mem_ack = 1;
      rst_n = 1'b0;
      #1;
      check_all_zero("reset_async");
      @(posedge clk); #1;
      check_all_zero("reset_hold");
      if_req = 0; lsu_req = 0; mem_ack = 1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      idle(1); idle(1); idle(0);

      // Randomized traffic.
      ack_pct = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) ack_pct = $urandom_range(20, 100);
         if_req    = ($urandom_range(0, 3) != 0);
         if_addr   = $urandom;
         flush_if  = ($urandom_range(0, 7) == 0);
         lsu_req   = ($urandom_range(0, 2) != 0);
         lsu_we    = $urandom_range(0, 1);
         lsu_addr  = $urandom;
         lsu_wdata = $urandom;
         lsu_be    = 4'($urandom_range(0, 15));
         mem_ack   = mem_req ? ($urandom_range(1, 100) <= ack_pct) : ($urandom_range(0, 7) == 0);
         mem_rdata = $urandom;
         @(posedge clk); #1;
      end

      for (int i = 0; i < 6; i++) idle(1);
      idle(0); idle(0);
      chk("drain_txn", tq.size(),  0);
      chk("drain_if",  ifq.size(), 0);
      chk("drain_lsu", lsq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
